// File: rtl/msp_pkg.sv
// rtl/msp_pkg.sv - shared MSP v1 framing constants, command IDs and state encoding
package msp_pkg;

  localparam logic [7:0] MSP_SYNC0       = 8'h24;
  localparam logic [7:0] MSP_SYNC1       = 8'h4D;
  localparam logic [7:0] MSP_DIR_TO_FC   = 8'h3C;
  localparam logic [7:0] MSP_DIR_FROM_FC = 8'h3E;
  localparam logic [7:0] MSP_DIR_ERR     = 8'h21;

  localparam logic [7:0] MSP_API_VERSION = 8'h01;
  localparam logic [7:0] MSP_FC_VARIANT  = 8'h02;
  localparam logic [7:0] MSP_IDENT       = 8'h64;
  localparam logic [7:0] MSP_STATUS      = 8'h65;
  localparam logic [7:0] MSP_RAW_IMU     = 8'h66;
  localparam logic [7:0] MSP_RC          = 8'h69;
  localparam logic [7:0] MSP_ATTITUDE    = 8'h6C;
  localparam logic [7:0] MSP_SET_RAW_RC  = 8'hC8;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_DOLLAR = 4'd1,
    S_M      = 4'd2,
    S_DIR    = 4'd3,
    S_LEN    = 4'd4,
    S_CMD    = 4'd5,
    S_DATA   = 4'd6,
    S_CRC    = 4'd7
  } msp_tx_state_e;

  function automatic logic [7:0] msp_xor8(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/msp_tx_if.sv
// rtl/msp_tx_if.sv - response capture and UART byte stream bundle for msp_tx
interface msp_tx_if #(parameter int MAX_PAYLOAD = 16);

  logic [7:0]               rsp_cmd;
  logic [7:0]               rsp_len;
  logic [MAX_PAYLOAD*8-1:0] rsp_payload;
  logic                     rsp_error;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;

  // master: response producer plus UART sink; slave: the transmitter itself
  modport master (
    output rsp_cmd, rsp_len, rsp_payload, rsp_error, rsp_valid, tx_ready,
    input  rsp_ready, tx_data, tx_valid
  );

  modport slave (
    input  rsp_cmd, rsp_len, rsp_payload, rsp_error, rsp_valid, tx_ready,
    output rsp_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/msp_tx.sv
// rtl/msp_tx.sv - MSP v1 response serialiser onto a byte-wide UART TX stream
module msp_tx
  import msp_pkg::*;
#(
  parameter int MAX_PAYLOAD = 16
) (
  input  logic       clk,
  input  logic       rst,
  msp_tx_if.slave    bus,
  output logic       busy,
  output logic [3:0] dbg_state
);

  msp_tx_state_e            state, state_n;
  logic [7:0]               cmd_r, cmd_n;
  logic                     err_r, err_n;
  logic [7:0]               len_r, len_n;
  logic [7:0]               idx, idx_n;
  logic [7:0]               csum, csum_n;
  logic [MAX_PAYLOAD*8-1:0] shift_r, shift_n;
  logic [7:0]               data_r, data_n;
  logic                     valid_r, valid_n;
  logic [7:0]               eff_len;
  logic                     xfer;

  assign eff_len       = (bus.rsp_len > 8'(MAX_PAYLOAD)) ? 8'(MAX_PAYLOAD) : bus.rsp_len;
  assign xfer          = valid_r && bus.tx_ready;
  assign bus.rsp_ready = (state == S_IDLE);
  assign bus.tx_data   = data_r;
  assign bus.tx_valid  = valid_r;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cmd_r   <= '0;
      err_r   <= 1'b0;
      len_r   <= '0;
      idx     <= '0;
      csum    <= '0;
      shift_r <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      state   <= state_n;
      cmd_r   <= cmd_n;
      err_r   <= err_n;
      len_r   <= len_n;
      idx     <= idx_n;
      csum    <= csum_n;
      shift_r <= shift_n;
      data_r  <= data_n;
      valid_r <= valid_n;
    end
  end

  always_ff @(posedge clk) begin
    dbg_state <= state;
  end

  // data_n is the byte presented by state_n, so tx_data leaves a flop with no tx_ready path
  always_comb begin
    state_n = state;
    cmd_n   = cmd_r;
    err_n   = err_r;
    len_n   = len_r;
    idx_n   = idx;
    csum_n  = csum;
    shift_n = shift_r;
    data_n  = data_r;
    valid_n = valid_r;
    case (state)
      S_IDLE: begin
        if (bus.rsp_valid) begin
          state_n = S_DOLLAR;
          cmd_n   = bus.rsp_cmd;
          err_n   = bus.rsp_error;
          len_n   = eff_len;
          csum_n  = eff_len;
          shift_n = bus.rsp_payload;
          idx_n   = '0;
          data_n  = MSP_SYNC0;
          valid_n = 1'b1;
        end
      end
      S_DOLLAR: if (xfer) begin
        state_n = S_M;
        data_n  = MSP_SYNC1;
      end
      S_M: if (xfer) begin
        state_n = S_DIR;
        data_n  = err_r ? MSP_DIR_ERR : MSP_DIR_FROM_FC;
      end
      S_DIR: if (xfer) begin
        state_n = S_LEN;
        data_n  = len_r;
      end
      S_LEN: if (xfer) begin
        state_n = S_CMD;
        data_n  = cmd_r;
      end
      S_CMD: if (xfer) begin
        csum_n = msp_xor8(csum, cmd_r);
        idx_n  = '0;
        if (len_r == 8'd0) begin
          state_n = S_CRC;
          data_n  = csum_n;
        end else begin
          state_n = S_DATA;
          data_n  = shift_r[7:0];
        end
      end
      S_DATA: if (xfer) begin
        csum_n  = msp_xor8(csum, shift_r[7:0]);
        shift_n = shift_r >> 8;
        idx_n   = idx + 8'd1;
        if (idx == len_r - 8'd1) begin
          state_n = S_CRC;
          data_n  = csum_n;
        end else begin
          data_n  = shift_n[7:0];
        end
      end
      S_CRC: if (xfer) begin
        state_n = S_IDLE;
        data_n  = '0;
        valid_n = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_msp_tx.sv
// tb/tb_msp_tx.sv - randomized self-checking bench for msp_tx against a frame-level model
module tb_msp_tx;

  localparam int MP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [3:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;

  msp_tx_if #(.MAX_PAYLOAD(MP)) bus();

  msp_tx #(.MAX_PAYLOAD(MP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MP*8-1:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected frame built straight from the protocol rules; drive, then follow tx bytes
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] len,
                           input logic [MP*8-1:0] pl, input logic err,
                           input bit rnd_ready, input bit noisy);
    logic [7:0] exp_q[$];
    logic [7:0] eff, x, pd;
    logic       pv, pr;
    int         w, k, cyc;
    eff = (len > 8'(MP)) ? 8'(MP) : len;
    x = eff ^ cmd;
    exp_q = {8'h24, 8'h4D, (err ? 8'h21 : 8'h3E), eff, cmd};
    for (int i = 0; i < int'(eff); i++) begin
      exp_q.push_back(pl[i*8 +: 8]);
      x ^= pl[i*8 +: 8];
    end
    exp_q.push_back(x);

    w = 0;
    while (!bus.rsp_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("ready_before_capture", {31'd0, bus.rsp_ready}, 32'd1);
    bus.rsp_cmd     = cmd;
    bus.rsp_len     = len;
    bus.rsp_payload = pl;
    bus.rsp_error   = err;
    bus.rsp_valid   = 1'b1;
    @(posedge clk); #1;
    bus.rsp_valid   = noisy;
    bus.rsp_cmd     = 8'($urandom);
    bus.rsp_len     = 8'($urandom);
    bus.rsp_payload = rand_payload();
    bus.rsp_error   = 1'($urandom);
    check("first_valid", {31'd0, bus.tx_valid}, 32'd1);
    check("first_byte", {24'd0, bus.tx_data}, 32'h24);
    check("busy_in_frame", {31'd0, busy}, 32'd1);

    k = 0;
    cyc = 0;
    while (k < exp_q.size() && cyc < 2000) begin
      bus.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = bus.tx_valid;
      pd = bus.tx_data;
      pr = bus.tx_ready;
      @(posedge clk); #1;
      cyc++;
      if (pv && pr) begin
        check($sformatf("byte%0d", k), {24'd0, pd}, {24'd0, exp_q[k]});
        k++;
      end else if (pv) begin
        check("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("hold_data", {24'd0, bus.tx_data}, {24'd0, pd});
      end
    end
    bus.rsp_valid = 1'b0;
    check("frame_length", k, exp_q.size());
    if (!rnd_ready) check("cycles_per_frame", cyc, exp_q.size());
    check("idle_ready_after", {31'd0, bus.rsp_ready}, 32'd1);
    check("idle_valid_after", {31'd0, bus.tx_valid}, 32'd0);
    check("idle_busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [MP*8-1:0] pl;
    rst             = 1'b1;
    bus.rsp_cmd     = '0;
    bus.rsp_len     = '0;
    bus.rsp_payload = '0;
    bus.rsp_error   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.tx_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_ready", {31'd0, bus.rsp_ready}, 32'd1);
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dbg_state", {28'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(8'h64, 8'd0, '0, 1'b0, 1'b0, 1'b0);
    pl = '0;
    pl[15:0] = 16'h0201;
    run_frame(8'h6C, 8'd2, pl, 1'b0, 1'b0, 1'b0);
    run_frame(8'h05, 8'd0, '0, 1'b1, 1'b0, 1'b0);
    run_frame(8'h6C, 8'd2, pl, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MP; i++) pl[i*8 +: 8] = 8'(i);
    run_frame(8'h69, 8'd20, pl, 1'b0, 1'b0, 1'b0);

    // abandon a frame while it is in the payload phase
    bus.rsp_cmd     = 8'h66;
    bus.rsp_len     = 8'd8;
    bus.rsp_payload = rand_payload();
    bus.rsp_error   = 1'b0;
    bus.rsp_valid   = 1'b1;
    bus.tx_ready    = 1'b1;
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("dbg_state_in_frame", {31'd0, (dbg_state != 4'd0)}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rsp_ready", {31'd0, bus.rsp_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_dbg_state", {28'd0, dbg_state}, 32'd0);
    run_frame(8'h65, 8'd3, rand_payload(), 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      run_frame(8'($urandom), 8'($urandom_range(0, 20)), rand_payload(),
                1'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/msp_tx.md
Name: msp_tx

Overview:
MSP v1 response transmitter; the outbound counterpart of the MSP packet receiver. It accepts one parsed response (cmd, len, packed payload) from the command handler and serialises it onto a byte-wide UART TX interface.
- Normal frames: `'$' 'M' '>' len cmd payload... checksum`.
- Error frames: direction byte `'!'`.
- Byte-level backpressure comes from the UART transmitter.

Parameters:
- MAX_PAYLOAD, 16, payload buffer depth in bytes; same packing as the receiver (byte i at bits [i*8 +: 8]).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rsp_cmd  input  8  MSP command ID to send
- rsp_len  input  8  payload length requested
- rsp_payload  input  MAX_PAYLOAD*8  packed payload, byte 0 in LSBs
- rsp_error  input  1  1 = send error frame (dir `'!'`, 0x21), 0 = normal (dir `'>'`, 0x3E)
- rsp_valid  input  1  response available
- rsp_ready  output 1  block idle, can capture a response
- tx_data  output 8  byte to UART TX
- tx_valid  output 1  tx_data valid
- tx_ready  input  1  UART TX accepts byte this cycle
- busy  output 1  frame in progress (state != S_IDLE)
- dbg_state  output 4  registered copy of state, one cycle delayed

Behaviour:
- Reset values: rsp_ready=1 (combinational from S_IDLE after reset), tx_valid=0, tx_data=0x00, busy=0, dbg_state=0; internal buffers and checksum cleared.
- Input handshake: capture when rsp_valid && rsp_ready at a rising edge.
  - rsp_ready = (state == S_IDLE), combinational.
  - cmd, error flag and full payload are copied into internal registers, so inputs may change the next cycle.
- Length clamp: eff_len = min(rsp_len, MAX_PAYLOAD). eff_len is used both for the transmitted len byte and for the checksum.
- Output handshake: a byte transfers on an edge where tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer, except on rst.
- States (4-bit encoding) and the byte each presents:
  - S_IDLE: no byte.
  - S_DOLLAR: 0x24.
  - S_M: 0x4D.
  - S_DIR: 0x3E or 0x21.
  - S_LEN: eff_len.
  - S_CMD: cmd.
  - S_DATA: payload[idx].
  - S_CRC: checksum.
- Transitions:
  - IDLE to DOLLAR on capture.
  - Each non-IDLE state advances only on a transfer.
  - CMD goes to CRC if eff_len==0, otherwise to DATA with idx=0.
  - DATA increments idx per transfer and goes to CRC after byte eff_len-1.
  - CRC goes to IDLE on transfer.
- Latency: capture at edge N gives tx_valid=1 with 0x24 in cycle N+1. With tx_ready held at 1, one byte per cycle. Frame length = 6 + eff_len bytes.
- Back-to-back frames: the capture edge of a new response can be the edge right after the CRC transfer; one IDLE cycle is permitted between frames.
- Checksum: 8-bit XOR of len, cmd and every payload byte. Initialised to eff_len on capture. Updated as bytes are sent, or precomputed; either is acceptable if the output is identical.
- Outputs (tx_data, tx_valid) are registered; there is no combinational path from tx_ready to tx_data.
- rst mid-frame: next cycle tx_valid=0, state S_IDLE, partial frame abandoned.
- rsp_valid while busy: ignored (not captured); the producer holds it until rsp_ready.
- dbg_state updates every cycle, including during rst.

Decomposition:
- Shared package msp_pkg:
  - Framing constants MSP_SYNC0=0x24, MSP_SYNC1=0x4D, MSP_DIR_TO_FC=0x3C, MSP_DIR_FROM_FC=0x3E, MSP_DIR_ERR=0x21.
  - Common MSP command ID constants.
  - Optional function msp_xor8.
  - The receiver is migrated to the same package.
- No sub-module: a single FSM with a payload shift/index mux. The top-level wiring (rx → handler → tx) lives in a separate msp wrapper.

Test Plan:
- Zero-length: cmd=0x64, len=0, error=0, tx_ready=1 → bytes 24 4D 3E 00 64 64, one per cycle; first byte the cycle after capture; rsp_ready returns high afterwards.
- Payload: cmd=0x6C, len=2, payload [0x01,0x02] → 24 4D 3E 02 6C 01 02 6D.
- Error frame: error=1, cmd=0x05, len=0 → 24 4D 21 00 05 05.
- Backpressure: same as the payload case with tx_ready random (~50%) → identical byte sequence; tx_data/tx_valid stable whenever tx_ready=0; no duplicated or dropped bytes.
- Clamp: MAX_PAYLOAD=16, len=20, payload bytes 0x00..0x0F → len byte 0x10, 16 data bytes, checksum = 0x10 ^ cmd ^ (XOR of 0x00..0x0F = 0x00).
- Reset mid-frame: assert rst during S_DATA → tx_valid=0 the next cycle; a new capture afterwards emits a complete, correct frame starting with 0x24.
